// File: rtl/code_loader_pkg.sv
// Shared types for the boot-time code loader: FSM state encoding and sizing helpers.
package code_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_CNT_HI  = 3'd0,
    S_CNT_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_CHK     = 3'd4,
    S_RUN     = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  // Largest word count a frame may declare for a given code-memory address width.
  function automatic int max_words(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/code_loader_register.sv
// Enable-loaded output register with asynchronous active-high reset to zero.
module code_loader_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/code_loader.sv
// Boot loader: reassembles a framed big-endian byte stream into code-memory writes and
// releases the processor with run once the frame XOR checksum matches.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr_in,
  output logic [WORD_W-1:0] code_in,
  output logic              run,
  output logic              busy,
  output logic              error
);

  localparam logic [15:0] MAX_N = 16'(max_words(ADDR_W));

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [BYTE_W-1:0]   chk_q, chk_d;
  logic                w_en_q, w_en_d;
  logic                rx_ready_q, rx_ready_d;
  logic                busy_q, busy_d;
  logic                run_q, run_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [WORD_W-1:0]   wr_data_d;

  logic                accept;
  logic [ADDR_W:0]     cnt_inc;
  logic [15:0]         n_word;

  assign accept  = rx_valid && rx_ready_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign n_word  = {hi_q, rx_data};

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    hi_d      = hi_q;
    chk_d     = chk_q;
    w_en_d    = 1'b0;
    wr_addr_d = cnt_q[ADDR_W-1:0];
    wr_data_d = WORD_W'({hi_q, rx_data});

    if (load_req) begin
      // Abort wins over a byte accepted in the same cycle; that byte is dropped.
      state_d = S_CNT_HI;
      cnt_d   = '0;
      chk_d   = '0;
    end else if (accept) begin
      case (state_q)
        S_CNT_HI: begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_CNT_LO;
        end
        S_CNT_LO: begin
          chk_d = chk_q ^ rx_data;
          if (n_word == 16'd0 || n_word > MAX_N) begin
            state_d = S_ERR;
          end else begin
            n_d     = n_word[ADDR_W:0];
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          chk_d   = chk_q ^ rx_data;
          w_en_d  = 1'b1;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == n_q) ? S_CHK : S_DATA_HI;
        end
        S_CHK: begin
          state_d = (rx_data == chk_q) ? S_RUN : S_ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Status outputs are registered copies of the decoded next state.
    rx_ready_d = state_d inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHK};
    busy_d     = state_d inside {S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHK};
    run_d      = (state_d == S_RUN);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CNT_HI;
      cnt_q      <= '0;
      n_q        <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      w_en_q     <= 1'b0;
      rx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      run_q      <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      hi_q       <= hi_d;
      chk_q      <= chk_d;
      w_en_q     <= w_en_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      run_q      <= run_d;
      error_q    <= error_d;
    end
  end

  // Address and data load together with the strobe and hold until the next one.
  code_loader_register #(.WIDTH(ADDR_W)) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_en_d),
    .d   (wr_addr_d),
    .q   (code_addr_in)
  );

  code_loader_register #(.WIDTH(WORD_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_en_d),
    .d   (wr_data_d),
    .q   (code_in)
  );

  assign code_w_en = w_en_q;
  assign rx_ready  = rx_ready_q;
  assign busy      = busy_q;
  assign run       = run_q;
  assign error     = error_q;

endmodule

// File: tb/tb_code_loader.sv
// Randomized scoreboard bench for code_loader: frames are built from the framing rules,
// expected writes are queued, and a negedge monitor checks every strobe.
module tb_code_loader;

  localparam int ADDR_W = 9;
  localparam int WORD_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              load_req;
  logic              code_w_en;
  logic [ADDR_W-1:0] code_addr_in;
  logic [WORD_W-1:0] code_in;
  logic              run;
  logic              busy;
  logic              error;

  int n_checks     = 0;
  int n_fail       = 0;
  int strobe_count = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  frm[$];
  logic [15:0] words[$];

  always #5 clk = ~clk;

  code_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .load_req     (load_req),
    .code_w_en    (code_w_en),
    .code_addr_in (code_addr_in),
    .code_in      (code_in),
    .run          (run),
    .busy         (busy),
    .error        (error)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0 && code_w_en === 1'b1) begin
      strobe_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(code_addr_in), 32'(e.addr));
        check("wr_data", 32'(code_in), 32'(e.data));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference framing: count bytes, big-endian words, XOR of every preceding byte.
  task automatic make_frame();
    logic [7:0] x;
    frm.delete();
    frm.push_back(8'(words.size() >> 8));
    frm.push_back(8'(words.size()));
    foreach (words[i]) begin
      frm.push_back(words[i][15:8]);
      frm.push_back(words[i][7:0]);
    end
    x = 8'h00;
    foreach (frm[i]) x = x ^ frm[i];
    frm.push_back(x);
  endtask

  task automatic push_expected(input int k);
    for (int i = 0; i < k; i++) exp_q.push_back('{addr: i, data: int'(words[i])});
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    check("rx_ready_before_byte", 32'(rx_ready), 32'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) begin
      idle($urandom_range(0, max_gap));
      put_byte(frm[i]);
      if (i == 0) check("busy_after_first_byte", 32'(busy), 32'd1);
    end
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    check("lr_run", 32'(run), 32'd0);
    check("lr_error", 32'(error), 32'd0);
    check("lr_busy", 32'(busy), 32'd0);
    check("lr_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  // Sends a whole frame built from words[]; expect_ok says whether the checksum matches.
  task automatic run_frame(input bit expect_ok, input int max_gap);
    int last;
    last = frm.size() - 1;
    push_expected(words.size());
    send_range(0, last - 1, max_gap);
    idle($urandom_range(0, max_gap));
    check("run_before_chk", 32'(run), 32'd0);
    put_byte(frm[last]);
    check("end_run", 32'(run), 32'(expect_ok));
    check("end_error", 32'(error), 32'(!expect_ok));
    check("end_rx_ready", 32'(rx_ready), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic bad_count(input logic [7:0] hi, input logic [7:0] lo);
    int s0;
    s0 = strobe_count;
    frm.delete();
    frm.push_back(hi);
    frm.push_back(lo);
    send_range(0, 1, 0);
    check("badcnt_error", 32'(error), 32'd1);
    check("badcnt_run", 32'(run), 32'd0);
    check("badcnt_rx_ready", 32'(rx_ready), 32'd0);
    idle(3);
    check("badcnt_no_strobe", 32'(strobe_count), 32'(s0));
    pulse_load_req();
  endtask

  initial begin
    int s0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    #12;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_w_en", 32'(code_w_en), 32'd0);
    check("rst_addr", 32'(code_addr_in), 32'd0);
    check("rst_data", 32'(code_in), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-word frame at full rate, then the same frame with a wrong checksum byte.
    words = '{16'h1234, 16'hABCD};
    make_frame();
    run_frame(1'b1, 0);
    pulse_load_req();
    frm[frm.size() - 1] = 8'h41;
    run_frame(1'b0, 0);
    pulse_load_req();

    bad_count(8'h00, 8'h00);
    bad_count(8'h02, 8'h01);

    // Maximum frame, data equals address, randomly gapped.
    words.delete();
    for (int i = 0; i < 512; i++) words.push_back(16'(i));
    make_frame();
    strobe_count = 0;
    run_frame(1'b1, 2);
    check("max_strobe_count", 32'(strobe_count), 32'd512);
    check("max_last_addr", 32'(code_addr_in), 32'd511);
    check("max_last_data", 32'(code_in), 32'h01FF);

    // load_req during run.
    check("run_held", 32'(run), 32'd1);
    pulse_load_req();

    // load_req together with a word's low byte: that word is never written.
    words = '{16'h5A5A, 16'hC3C3, 16'h0F0F};
    make_frame();
    push_expected(1);
    send_range(0, 4, 1);
    s0 = strobe_count;
    rx_valid = 1'b1;
    rx_data  = frm[5];
    pulse_load_req();
    rx_valid = 1'b0;
    idle(3);
    check("abort_no_strobe", 32'(strobe_count), 32'(s0));
    check("abort_drained", 32'(exp_q.size()), 32'd0);

    // Fresh frame reloads from address 0.
    words = '{16'h7E57, 16'h0001};
    make_frame();
    run_frame(1'b1, 1);
    pulse_load_req();

    // Asynchronous reset in the middle of a word.
    words = '{16'hBEEF, 16'h1357};
    make_frame();
    push_expected(1);
    send_range(0, 4, 0);
    s0 = strobe_count;
    rx_valid = 1'b1;
    rx_data  = frm[5];
    #2 rst = 1'b1;
    #1;
    check("arst_rx_ready", 32'(rx_ready), 32'd1);
    check("arst_w_en", 32'(code_w_en), 32'd0);
    check("arst_addr", 32'(code_addr_in), 32'd0);
    check("arst_data", 32'(code_in), 32'd0);
    check("arst_run", 32'(run), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    rx_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(3);
    check("arst_no_strobe", 32'(strobe_count), 32'(s0));
    check("arst_drained", 32'(exp_q.size()), 32'd0);

    // Random frames, some with a corrupted checksum.
    for (int t = 0; t < 8; t++) begin
      bit good;
      int n;
      n    = $urandom_range(1, 24);
      good = 1'($urandom_range(0, 1));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      make_frame();
      if (!good) frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'(1 << $urandom_range(0, 7));
      run_frame(good, 2);
      pulse_load_req();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
